// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - shared encodings for the RV32I multicycle control path
// Purpose: opcode constants, ImmSel/ALUSel/WBSel encodings, FSM state and
//          instruction-class enums, plus the funct3/funct7 -> ALU op helper.
// Ports:   none (package)
package rv_ctrl_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] IMM_R = 3'd0;
    localparam logic [2:0] IMM_I = 3'd1;
    localparam logic [2:0] IMM_S = 3'd2;
    localparam logic [2:0] IMM_B = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;
    localparam logic [2:0] IMM_J = 3'd5;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam logic [1:0] WB_MDR = 2'd0;
    localparam logic [1:0] WB_ALU = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        CL_OP, CL_OPIMM, CL_LOAD, CL_STORE, CL_BRANCH,
        CL_LUI, CL_AUIPC, CL_JAL, CL_JALR, CL_ILLEGAL
    } iclass_t;

    // funct7[5] selects SUB only for register-register ops (ADDI has no SUB
    // form), but selects SRA for both shift-right flavours.
    function automatic logic [3:0] alu_from_funct(input logic [2:0] f3,
                                                  input logic       f7b5,
                                                  input logic       is_reg);
        logic [3:0] op;
        case (f3)
            3'd0:    op = (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = f7b5 ? ALU_SRA : ALU_SRL;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv_main_decoder.sv
// rtl/rv_main_decoder.sv - combinational opcode/funct decode for the control FSM
// Purpose: classify the latched instruction and produce ImmSel, ALUSel, legal.
// Ports:   opcode/funct3/funct7_b5 in; iclass, imm_sel, alu_sel, legal out.
import rv_ctrl_pkg::*;

module rv_main_decoder (
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    output iclass_t    iclass,
    output logic [2:0] imm_sel,
    output logic [3:0] alu_sel,
    output logic       legal
);

    always_comb begin
        iclass  = CL_ILLEGAL;
        imm_sel = IMM_R;
        alu_sel = ALU_ADD;
        case (opcode)
            OPC_OP: begin
                iclass  = CL_OP;
                alu_sel = alu_from_funct(funct3, funct7_b5, 1'b1);
            end
            OPC_OPIMM: begin
                iclass  = CL_OPIMM;
                imm_sel = IMM_I;
                alu_sel = alu_from_funct(funct3, funct7_b5, 1'b0);
            end
            OPC_LOAD: begin
                iclass  = CL_LOAD;
                imm_sel = IMM_I;
            end
            OPC_STORE: begin
                iclass  = CL_STORE;
                imm_sel = IMM_S;
            end
            OPC_BRANCH: begin
                // funct3 010/011 has no branch meaning
                if (funct3[2:1] != 2'b01) begin
                    iclass  = CL_BRANCH;
                    imm_sel = IMM_B;
                end
            end
            OPC_LUI: begin
                iclass  = CL_LUI;
                imm_sel = IMM_U;
                alu_sel = ALU_PASSB;
            end
            OPC_AUIPC: begin
                iclass  = CL_AUIPC;
                imm_sel = IMM_U;
            end
            OPC_JAL: begin
                iclass  = CL_JAL;
                imm_sel = IMM_J;
            end
            OPC_JALR: begin
                iclass  = CL_JALR;
                imm_sel = IMM_I;
            end
            default: ;
        endcase
    end

    assign legal = (iclass != CL_ILLEGAL);

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - FETCH/DECODE/EXEC/MEM/WB control FSM for the RV32I multicycle core
// Purpose: sequences the datapath; outputs are combinational from state and Instr.
// Ports:   clk, rst_n, Instr, BrEq, BrLT, MemReady in; MemReq, MemRW, IorD,
//          IRWrite, MDRWrite, PCWrite, PCSel, ImmSel, ASel, BSel, ALUSel, BrUn,
//          RegWEn, WBSel, State out; Trap out when MULTICYCLE_CTRL_TRAP_EN is defined
//          (illegal opcodes then lock in TRAP instead of acting as NOP).
import rv_ctrl_pkg::*;

module multicycle_ctrl #(
    parameter logic [2:0] RESET_STATE = 3'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] Instr,
    input  logic        BrEq,
    input  logic        BrLT,
    input  logic        MemReady,
    output logic        MemReq,
    output logic        MemRW,
    output logic        IorD,
    output logic        IRWrite,
    output logic        MDRWrite,
    output logic        PCWrite,
    output logic        PCSel,
    output logic [2:0]  ImmSel,
    output logic        ASel,
    output logic        BSel,
    output logic [3:0]  ALUSel,
    output logic        BrUn,
    output logic        RegWEn,
    output logic [1:0]  WBSel,
    output logic [2:0]  State
`ifdef MULTICYCLE_CTRL_TRAP_EN
    ,
    output logic        Trap
`endif
);

    state_t     state;
    iclass_t    dec_class;
    logic [2:0] dec_imm;
    logic [3:0] dec_alu;
    logic       dec_legal;
    logic       ex_asel;
    logic       ex_bsel;
    logic       taken;
    logic       unused_instr;

    assign unused_instr = ^{Instr[31], Instr[29:15], Instr[11:7]};

    rv_main_decoder u_dec (
        .opcode    (Instr[6:0]),
        .funct3    (Instr[14:12]),
        .funct7_b5 (Instr[30]),
        .iclass    (dec_class),
        .imm_sel   (dec_imm),
        .alu_sel   (dec_alu),
        .legal     (dec_legal)
    );

    // Operand selects chosen in EXEC; MEM and WB repeat them so the ALU
    // result (address or jump target) stays valid on the combinational datapath.
    always_comb begin
        ex_asel = 1'b0;
        ex_bsel = 1'b1;
        case (dec_class)
            CL_OP:                       ex_bsel = 1'b0;
            CL_AUIPC, CL_BRANCH, CL_JAL: ex_asel = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        case (Instr[14:12])
            3'b000:         taken = BrEq;
            3'b001:         taken = !BrEq;
            3'b100, 3'b110: taken = BrLT;
            default:        taken = !BrLT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= state_t'(RESET_STATE);
        end else begin
            case (state)
                S_FETCH:  if (MemReady) state <= S_DECODE;
                S_DECODE: state <= S_EXEC;
                S_EXEC: begin
                    if (!dec_legal) begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
                        state <= S_TRAP;
`else
                        state <= S_FETCH;
`endif
                    end else if (dec_class == CL_BRANCH) begin
                        state <= S_FETCH;
                    end else if (dec_class == CL_LOAD || dec_class == CL_STORE) begin
                        state <= S_MEM;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_MEM: if (MemReady) state <= (dec_class == CL_STORE) ? S_FETCH : S_WB;
                S_WB:  state <= S_FETCH;
`ifdef MULTICYCLE_CTRL_TRAP_EN
                S_TRAP: state <= S_TRAP;
`endif
                default: state <= S_FETCH;
            endcase
        end
    end

    assign State = state;

    always_comb begin
        MemReq   = 1'b0;
        MemRW    = 1'b0;
        IorD     = 1'b0;
        IRWrite  = 1'b0;
        MDRWrite = 1'b0;
        PCWrite  = 1'b0;
        PCSel    = 1'b0;
        ImmSel   = IMM_R;
        ASel     = 1'b0;
        BSel     = 1'b0;
        ALUSel   = ALU_ADD;
        BrUn     = 1'b0;
        RegWEn   = 1'b0;
        WBSel    = WB_MDR;
`ifdef MULTICYCLE_CTRL_TRAP_EN
        Trap     = 1'b0;
`endif
        // During reset every output is held low, independent of the clock.
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    MemReq  = 1'b1;
                    IRWrite = MemReady;
                end
                S_DECODE: ImmSel = dec_imm;
                S_EXEC: begin
                    if (!dec_legal) begin
`ifndef MULTICYCLE_CTRL_TRAP_EN
                        PCWrite = 1'b1;
`endif
                    end else begin
                        ImmSel = dec_imm;
                        ASel   = ex_asel;
                        BSel   = ex_bsel;
                        ALUSel = dec_alu;
                        if (dec_class == CL_BRANCH) begin
                            BrUn    = Instr[13];
                            PCWrite = 1'b1;
                            PCSel   = taken;
                        end
                    end
                end
                S_MEM: begin
                    MemReq = 1'b1;
                    IorD   = 1'b1;
                    MemRW  = (dec_class == CL_STORE);
                    ImmSel = dec_imm;
                    ASel   = ex_asel;
                    BSel   = ex_bsel;
                    ALUSel = dec_alu;
                    if (MemReady) begin
                        if (dec_class == CL_STORE) PCWrite  = 1'b1;
                        else                       MDRWrite = 1'b1;
                    end
                end
                S_WB: begin
                    RegWEn  = 1'b1;
                    PCWrite = 1'b1;
                    ImmSel  = dec_imm;
                    ASel    = ex_asel;
                    BSel    = ex_bsel;
                    ALUSel  = dec_alu;
                    if (dec_class == CL_LOAD) begin
                        WBSel = WB_MDR;
                    end else if (dec_class == CL_JAL || dec_class == CL_JALR) begin
                        WBSel = WB_PC4;
                        PCSel = 1'b1;
                    end else begin
                        WBSel = WB_ALU;
                    end
                end
`ifdef MULTICYCLE_CTRL_TRAP_EN
                S_TRAP: Trap = 1'b1;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Control FSM for the RV32I multicycle core. Sequences FETCH/DECODE/EXEC/MEM/WB and drives every datapath select: the immediate generator's ImmSel, ALU operand muxes, ALUSel, memory handshake, PC/IR/register-file write enables.
- Sits beside the datapath. Reads the latched instruction (IR) plus branch-comparator flags.
- Datapath is combinational from IR/registers, so ALU result stays valid while control holds the same selects.

Parameters:
- RESET_STATE, 3'd0, state entered on reset (FETCH); not intended to change.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- Instr  in  32  IR contents (stable from DECODE until next IRWrite)
- BrEq  in  1  rs1==rs2 from branch comparator
- BrLT  in  1  rs1<rs2 (signed unless BrUn)
- MemReady  in  1  memory access completes this cycle
- MemReq  out  1  memory access request
- MemRW  out  1  0=read, 1=write
- IorD  out  1  address select: 0=PC, 1=ALU result
- IRWrite  out  1  latch instruction
- MDRWrite  out  1  latch load data
- PCWrite  out  1  PC update enable
- PCSel  out  1  0=PC+4, 1=ALU result
- ImmSel  out  3  R=0, I=1, S=2, B=3, U=4, J=5
- ASel  out  1  0=rs1, 1=PC
- BSel  out  1  0=rs2, 1=Imm
- ALUSel  out  4  ALU operation (package encoding)
- BrUn  out  1  unsigned compare
- RegWEn  out  1  register-file write
- WBSel  out  2  0=MDR, 1=ALU, 2=PC+4
- State  out  3  current state (debug)

Behaviour:
- Reset: asynchronous, active-low. While rst_n=0: state=FETCH and all outputs forced to 0. First cycle after release is FETCH. Asserting rst_n mid-instruction aborts it; no PCWrite/RegWEn in that cycle.
- Outputs are combinational from state and Instr. Unlisted outputs are 0. ImmSel=R in FETCH.
- FETCH:
  - MemReq=1, IorD=0, MemRW=0.
  - Hold until MemReady=1; in that cycle IRWrite=1 and go to DECODE.
- DECODE:
  - ImmSel from opcode: OP→R; OP-IMM/LOAD/JALR→I; STORE→S; BRANCH→B; LUI/AUIPC→U; JAL→J.
  - Always go to EXEC.
- EXEC (ImmSel held):
  - OP: ASel=0, BSel=0, ALUSel from funct3/funct7[5]; go to WB.
  - OP-IMM: BSel=1; SRAI uses funct7[5]; go to WB.
  - LUI: BSel=1, ALUSel=PASSB; go to WB.
  - AUIPC: ASel=1, BSel=1, ADD; go to WB.
  - LOAD/STORE: BSel=1, ADD; go to MEM.
  - BRANCH:
    - ASel=1, BSel=1, ADD, BrUn=funct3[1].
    - Taken: BEQ=BrEq, BNE=!BrEq, BLT/BLTU=BrLT, BGE/BGEU=!BrLT.
    - PCWrite=1, PCSel=taken; go to FETCH.
  - JAL: ASel=1, BSel=1, ADD. JALR: ASel=0, BSel=1, ADD. Both go to WB.
  - Illegal opcode: PCWrite=1, PCSel=0 (NOP); go to FETCH.
- MEM:
  - MemReq=1, IorD=1, MemRW=1 for STORE else 0; EXEC ALU selects held.
  - Hold until MemReady.
  - Load: MDRWrite=1, go to WB.
  - Store: PCWrite=1, PCSel=0, go to FETCH.
- WB:
  - RegWEn=1 and PCWrite=1 for exactly one cycle, then FETCH.
  - WBSel: 0 for LOAD, 2 for JAL/JALR, else 1.
  - PCSel=1 for JAL/JALR (EXEC ALU selects held; ALU result LSB ignored by PC for JALR), else 0.
- Cycle counts with MemReady tied 1: branch/illegal 3; ALU/U/JAL/JALR 4; store 4; load 5. Each MemReady wait cycle adds 1.
- MemReady outside FETCH/MEM is ignored.

Optional Feature:
- Macro: MULTICYCLE_CTRL_TRAP_EN.
- Defined:
  - Adds state TRAP (State=5) and output Trap (1 bit).
  - Illegal opcode in EXEC goes to TRAP with no PCWrite.
  - TRAP asserts Trap=1, holds all other outputs 0, and is left only by reset.
- Undefined: no Trap port; illegal opcode behaves as NOP.

Decomposition:
- Package rv_ctrl_pkg:
  - Opcode constants.
  - ImmSel encodings: R/I/S/B/U/J = 0..5.
  - ALUSel encodings: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASSB 10.
  - WBSel encodings and state encodings.
- Sub-module rv_main_decoder (combinational): opcode/funct3/funct7 → instruction class, ImmSel, ALUSel, legal flag. FSM sequencing stays in multicycle_ctrl.

Test Plan:
- ADDI x1,x0,5 (0x00500093), MemReady=1 → states 0,1,2,4. ImmSel=1 in DECODE. WB: RegWEn=1, WBSel=1, PCWrite=1, PCSel=0.
- BEQ with BrEq=1, then BrEq=0 → 3 cycles each. EXEC: PCWrite=1, PCSel=1 then 0; ImmSel=3; never RegWEn.
- LW with MemReady low 2 cycles in MEM → MemReq=1, IorD=1 held 3 cycles. MDRWrite on the ready cycle. WB: WBSel=0. Total 7 cycles.
- SW (0x00112023) → MEM: MemRW=1; PCWrite=1 on MemReady; ImmSel=2; no RegWEn.
- JAL (0x008000EF) → ImmSel=5. WB: RegWEn=1, WBSel=2, PCSel=1.
- rst_n low in MEM of a load → all outputs 0 immediately. After release: FETCH with MemReq=1, IorD=0. Opcode 0x7F: NOP, or TRAP (Trap=1, State=5) with the macro defined.
